// File: rtl/seg7_scanner.sv
// Two-digit multiplexed 7-segment driver; shows an 8-bit value as two hex digits, refreshed once per frame.
// Latency: one cycle, registered outputs; value is snapshotted at the frame boundary, so display lags by at most 2*PRESCALE+1 cycles.
// Backpressure: none; free-running scan. blank_i darkens the outputs without disturbing the scan timing.
//
// Ports:
//   clk_i      rising-edge clock
//   rst_ni     asynchronous active-low reset
//   value_i    8-bit count to display; sampled only on the last cycle of a frame
//   blank_i    forces the display dark (one-cycle latency)
//   seg_o      segments {g,f,e,d,c,b,a}, registered, polarity set by SEG_ACTIVE_LOW
//   dig_sel_o  one-hot digit enable (bit0 = low nibble, bit1 = high nibble), registered
//   frame_o    one-cycle pulse when a new snapshot starts being scanned out
module seg7_scanner #(
    parameter int PRESCALE       = 8,
    parameter int DEAD           = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] value_i,
    input  logic       blank_i,
    output logic [6:0] seg_o,
    output logic [1:0] dig_sel_o,
    output logic       frame_o
);

    localparam int             CW      = $clog2(PRESCALE);
    localparam logic [CW-1:0]  C_LAST  = CW'(PRESCALE - 1);
    localparam logic [CW-1:0]  C_DEAD  = CW'(DEAD);
    // XOR masks applied at the output registers; reset values use them too,
    // so "inactive" is all-ones for an active-low board.
    localparam logic [6:0]     SEG_INV = {7{SEG_ACTIVE_LOW}};
    localparam logic [1:0]     DIG_INV = {2{SEG_ACTIVE_LOW}};

    typedef enum logic {
        SLOT_LO = 1'b0,
        SLOT_HI = 1'b1
    } slot_e;

    logic [CW-1:0] c_q, c_d;
    slot_e         slot_q, slot_d;
    logic [7:0]    snap_q, snap_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    dig_q, dig_d;
    logic          frame_q, frame_d;

    logic          wrap;
    logic          capture;
    logic          dark;
    logic [3:0]    nibble;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] r;
        case (n)
            4'h0:    r = 7'h3F;
            4'h1:    r = 7'h06;
            4'h2:    r = 7'h5B;
            4'h3:    r = 7'h4F;
            4'h4:    r = 7'h66;
            4'h5:    r = 7'h6D;
            4'h6:    r = 7'h7D;
            4'h7:    r = 7'h07;
            4'h8:    r = 7'h7F;
            4'h9:    r = 7'h6F;
            4'hA:    r = 7'h77;
            4'hB:    r = 7'h7C;
            4'hC:    r = 7'h39;
            4'hD:    r = 7'h5E;
            4'hE:    r = 7'h79;
            default: r = 7'h71;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            c_q     <= '0;
            slot_q  <= SLOT_LO;
            snap_q  <= '0;
            seg_q   <= SEG_INV;
            dig_q   <= DIG_INV;
            frame_q <= 1'b0;
        end else begin
            c_q     <= c_d;
            slot_q  <= slot_d;
            snap_q  <= snap_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            frame_q <= frame_d;
        end
    end

    always_comb begin
        wrap    = (c_q == C_LAST);
        c_d     = c_q + 1'b1;
        slot_d  = slot_q;
        if (wrap) begin
            c_d    = '0;
            slot_d = (slot_q == SLOT_LO) ? SLOT_HI : SLOT_LO;
        end

        // The snapshot reloads on the same edge that returns the scan to
        // slot 0, so both digits of a frame always come from one sample.
        capture = wrap && (slot_q == SLOT_HI);
        snap_d  = capture ? value_i : snap_q;
        frame_d = capture;

        // Dead-time at the start of every slot lets the previous digit's
        // driver turn off before the next one lights (anti-ghosting).
        nibble = (slot_q == SLOT_HI) ? snap_q[7:4] : snap_q[3:0];
        dark   = blank_i || (c_q < C_DEAD);

        seg_d = SEG_INV;
        dig_d = DIG_INV;
        if (!dark) begin
            seg_d = hex7(nibble) ^ SEG_INV;
            dig_d = ((slot_q == SLOT_HI) ? 2'b10 : 2'b01) ^ DIG_INV;
        end
    end

    assign seg_o     = seg_q;
    assign dig_sel_o = dig_q;
    assign frame_o   = frame_q;

endmodule

// File: tb/tb_seg7_scanner.sv
module tb_seg7_scanner;

    localparam int PS   = 8;
    localparam int DT   = 2;
    localparam int FLEN = 2 * PS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] value = 8'h00;
    logic       blank = 1'b0;

    logic [6:0] seg_h, seg_l;
    logic [1:0] dig_h, dig_l;
    logic       frame_h, frame_l;

    seg7_scanner #(.PRESCALE(PS), .DEAD(DT), .SEG_ACTIVE_LOW(1'b0)) u_hi (
        .clk_i(clk), .rst_ni(rst_n), .value_i(value), .blank_i(blank),
        .seg_o(seg_h), .dig_sel_o(dig_h), .frame_o(frame_h)
    );

    seg7_scanner #(.PRESCALE(PS), .DEAD(DT), .SEG_ACTIVE_LOW(1'b1)) u_lo (
        .clk_i(clk), .rst_ni(rst_n), .value_i(value), .blank_i(blank),
        .seg_o(seg_l), .dig_sel_o(dig_l), .frame_o(frame_l)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] seg;
        logic [1:0] dig;
        logic       frame;
    } obs_t;

    obs_t exp_q[$];
    obs_t act_h_q[$];
    obs_t act_l_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state: edges since reset release and displayed snapshot.
    int         k = 0;
    logic [7:0] snap_m = 8'h00;

    logic [6:0] dec_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic obs_t inv(input obs_t e);
        obs_t r;
        r       = e;
        r.seg   = ~e.seg;
        r.dig   = ~e.dig;
        return r;
    endfunction

    // Push the expected outputs for the coming edge, advance one clock,
    // record what both DUTs produced.
    task automatic tick();
        obs_t       e;
        int         p, c, s;
        logic [7:0] v;
        p = k % FLEN;
        c = p % PS;
        s = p / PS;
        e.frame = (p == FLEN - 1);
        if (blank || c < DT) begin
            e.seg = 7'h00;
            e.dig = 2'b00;
        end else begin
            e.dig = (s == 1) ? 2'b10 : 2'b01;
            e.seg = (s == 1) ? dec_tbl[snap_m[7:4]] : dec_tbl[snap_m[3:0]];
        end
        v = value;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        act_h_q.push_back({seg_h, dig_h, frame_h});
        act_l_q.push_back({seg_l, dig_l, frame_l});
        if (p == FLEN - 1) snap_m = v;
        k++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        value = 8'hA5;
        blank = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (seg_h !== 7'h00)   begin errors++; $display("FAIL reset_seg_hi act=%h exp=00", seg_h); end
        checks++; if (dig_h !== 2'b00)   begin errors++; $display("FAIL reset_dig_hi act=%b exp=00", dig_h); end
        checks++; if (frame_h !== 1'b0)  begin errors++; $display("FAIL reset_frame_hi act=%b exp=0", frame_h); end
        checks++; if (seg_l !== 7'h7F)   begin errors++; $display("FAIL reset_seg_lo act=%h exp=7f", seg_l); end
        checks++; if (dig_l !== 2'b11)   begin errors++; $display("FAIL reset_dig_lo act=%b exp=11", dig_l); end
        checks++; if (frame_l !== 1'b0)  begin errors++; $display("FAIL reset_frame_lo act=%b exp=0", frame_l); end
        rst_n  = 1'b1;
        k      = 0;
        snap_m = 8'h00;
    endtask

    task automatic test_first_frame();
        obs_t e, ah, al;
        int   lit = 0;
        run(FLEN);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); ah = act_h_q.pop_front(); al = act_l_q.pop_front();
            checks++; if (ah !== e)      begin errors++; $display("FAIL first_frame_hi act=%h exp=%h", ah, e); end
            checks++; if (al !== inv(e)) begin errors++; $display("FAIL first_frame_lo act=%h exp=%h", al, inv(e)); end
            if (ah.dig != 2'b00) begin
                lit++;
                checks++; if (ah.seg !== 7'h3F) begin errors++; $display("FAIL first_frame_zero act=%h exp=3f", ah.seg); end
            end
        end
        checks++; if (lit !== 2 * (PS - DT)) begin errors++; $display("FAIL first_frame_ontime act=%0d exp=%0d", lit, 2 * (PS - DT)); end
    endtask

    task automatic test_capture();
        obs_t e, ah, al;
        int   idx = 0, frames = 0, last = -1;
        run(2 * FLEN);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); ah = act_h_q.pop_front(); al = act_l_q.pop_front();
            checks++; if (ah !== e)      begin errors++; $display("FAIL capture_hi act=%h exp=%h", ah, e); end
            checks++; if (al !== inv(e)) begin errors++; $display("FAIL capture_lo act=%h exp=%h", al, inv(e)); end
            if (ah.dig == 2'b01) begin
                checks++; if (ah.seg !== 7'h6D) begin errors++; $display("FAIL capture_digit5 act=%h exp=6d", ah.seg); end
            end
            if (ah.dig == 2'b10) begin
                checks++; if (ah.seg !== 7'h77) begin errors++; $display("FAIL capture_digitA act=%h exp=77", ah.seg); end
            end
            if (ah.frame) begin
                frames++;
                if (last >= 0) begin
                    checks++; if (idx - last !== FLEN) begin errors++; $display("FAIL frame_period act=%0d exp=%0d", idx - last, FLEN); end
                end
                last = idx;
            end
            idx++;
        end
        checks++; if (frames !== 2) begin errors++; $display("FAIL frame_count act=%0d exp=2", frames); end
    endtask

    task automatic test_anti_tear();
        obs_t       e, ah, al;
        int         idx = 0;
        logic [6:0] lo_seg [3] = '{7'h6D, 7'h5B, 7'h66};
        logic [6:0] hi_seg [3] = '{7'h77, 7'h06, 7'h4F};
        value = 8'h12;
        run(FLEN);
        run(3);
        value = 8'h34;
        run(FLEN - 3);
        run(FLEN);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); ah = act_h_q.pop_front(); al = act_l_q.pop_front();
            checks++; if (ah !== e)      begin errors++; $display("FAIL anti_tear_hi act=%h exp=%h", ah, e); end
            checks++; if (al !== inv(e)) begin errors++; $display("FAIL anti_tear_lo act=%h exp=%h", al, inv(e)); end
            if (ah.dig == 2'b01) begin
                checks++; if (ah.seg !== lo_seg[idx / FLEN]) begin errors++; $display("FAIL anti_tear_d0 frame=%0d act=%h exp=%h", idx / FLEN, ah.seg, lo_seg[idx / FLEN]); end
            end
            if (ah.dig == 2'b10) begin
                checks++; if (ah.seg !== hi_seg[idx / FLEN]) begin errors++; $display("FAIL anti_tear_d1 frame=%0d act=%h exp=%h", idx / FLEN, ah.seg, hi_seg[idx / FLEN]); end
            end
            idx++;
        end
    endtask

    task automatic test_blank();
        obs_t e, ah, al;
        int   idx = 0;
        run(10);
        blank = 1'b1;
        run(3);
        blank = 1'b0;
        run(3 + FLEN);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); ah = act_h_q.pop_front(); al = act_l_q.pop_front();
            checks++; if (ah !== e)      begin errors++; $display("FAIL blank_hi act=%h exp=%h", ah, e); end
            checks++; if (al !== inv(e)) begin errors++; $display("FAIL blank_lo act=%h exp=%h", al, inv(e)); end
            if (idx >= 10 && idx <= 12) begin
                checks++; if ({ah.seg, ah.dig} !== 9'h000) begin errors++; $display("FAIL blank_dark act=%h exp=000", {ah.seg, ah.dig}); end
            end
            if (idx == 13) begin
                checks++; if ({ah.seg, ah.dig} !== {7'h4F, 2'b10}) begin errors++; $display("FAIL blank_resume act=%h exp=%h", {ah.seg, ah.dig}, {7'h4F, 2'b10}); end
            end
            if (idx == 15 || idx == 31) begin
                checks++; if (ah.frame !== 1'b1) begin errors++; $display("FAIL blank_frame act=%b exp=1", ah.frame); end
            end
            idx++;
        end
    endtask

    task automatic test_decode_sweep();
        obs_t e, ah, al;
        for (int v = 0; v <= 256; v++) begin
            value = 8'(v);
            run(FLEN);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front(); ah = act_h_q.pop_front(); al = act_l_q.pop_front();
                checks++; if (ah !== e)      begin errors++; $display("FAIL sweep_hi v=%0d act=%h exp=%h", v, ah, e); end
                checks++; if (al !== inv(e)) begin errors++; $display("FAIL sweep_lo v=%0d act=%h exp=%h", v, al, inv(e)); end
            end
        end
    endtask

    task automatic test_mid_reset();
        obs_t e, ah, al;
        int   idx = 0;
        run(11);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); ah = act_h_q.pop_front(); al = act_l_q.pop_front();
            checks++; if (ah !== e)      begin errors++; $display("FAIL pre_reset_hi act=%h exp=%h", ah, e); end
            checks++; if (al !== inv(e)) begin errors++; $display("FAIL pre_reset_lo act=%h exp=%h", al, inv(e)); end
        end
        rst_n = 1'b0;
        #1;
        checks++; if ({seg_h, dig_h, frame_h} !== 10'h000)              begin errors++; $display("FAIL async_reset_hi act=%h exp=000", {seg_h, dig_h, frame_h}); end
        checks++; if ({seg_l, dig_l, frame_l} !== {7'h7F, 2'b11, 1'b0}) begin errors++; $display("FAIL async_reset_lo act=%h exp=%h", {seg_l, dig_l, frame_l}, {7'h7F, 2'b11, 1'b0}); end
        @(posedge clk);
        #1;
        checks++; if ({seg_l, dig_l, frame_l} !== {7'h7F, 2'b11, 1'b0}) begin errors++; $display("FAIL held_reset_lo act=%h exp=%h", {seg_l, dig_l, frame_l}, {7'h7F, 2'b11, 1'b0}); end
        rst_n  = 1'b1;
        k      = 0;
        snap_m = 8'h00;
        value  = 8'h5A;
        run(2 * FLEN);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); ah = act_h_q.pop_front(); al = act_l_q.pop_front();
            checks++; if (ah !== e)      begin errors++; $display("FAIL post_reset_hi act=%h exp=%h", ah, e); end
            checks++; if (al !== inv(e)) begin errors++; $display("FAIL post_reset_lo act=%h exp=%h", al, inv(e)); end
            if (idx < FLEN - 1) begin
                checks++; if (ah.frame !== 1'b0) begin errors++; $display("FAIL post_reset_noframe idx=%0d act=%b exp=0", idx, ah.frame); end
                if (ah.dig != 2'b00) begin
                    checks++; if (ah.seg !== 7'h3F) begin errors++; $display("FAIL post_reset_zero idx=%0d act=%h exp=3f", idx, ah.seg); end
                end
            end
            idx++;
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_capture();
        test_anti_tear();
        test_blank();
        test_decode_sweep();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
